// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128 key-schedule sequencer.
// Loads a 128-bit cipher key, drives one key-expansion round per clock
// (rounds 1..10) and keeps all 11 round keys in an internal register file
// that the cipher datapath reads by index.  Bit 0 of every 128-bit word is
// the MSB of byte 0 (big-endian word and byte ordering throughout).

// One AES-128 key-expansion round: next round key from the previous one.
module key_exp (
    input  logic [0:127] key_exp_in,
    input  logic [3:0]   round_number,
    output logic [0:127] key_exp_out
);

    // Forward AES S-box, entry i at index i.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [7:0]  rcon;
    logic [0:31] w0;
    logic [0:31] w1;
    logic [0:31] w2;
    logic [0:31] w3;
    logic [0:31] temp;
    logic [0:31] n0;
    logic [0:31] n1;
    logic [0:31] n2;
    logic [0:31] n3;

    // Round constant; rounds outside 1..10 contribute nothing.
    always_comb begin
        rcon = 8'h00;
        case (round_number)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign w0 = key_exp_in[0:31];
    assign w1 = key_exp_in[32:63];
    assign w2 = key_exp_in[64:95];
    assign w3 = key_exp_in[96:127];

    // SubWord(RotWord(w3)) xor Rcon: rotation moves byte 1 to the front.
    assign temp = {SBOX[w3[8:15]] ^ rcon,
                   SBOX[w3[16:23]],
                   SBOX[w3[24:31]],
                   SBOX[w3[0:7]]};

    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign key_exp_out = {n0, n1, n2, n3};

endmodule

module key_schedule_ctrl #(
    parameter int NR         = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [0:127] key_in,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic [3:0]   rd_idx,
    output logic [0:127] rd_key
);

    localparam int          NSLOTS     = 11;
    localparam logic [3:0]  LAST_ROUND = 4'(NR);
    localparam logic [3:0]  LAST_SLOT  = 4'(NSLOTS - 1);

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    state_t       state;
    logic [3:0]   round_cnt;
    logic [0:127] work;
    logic [0:127] kexp_out;
    logic [0:127] slot_q [0:NSLOTS-1];
    logic [0:127] rd_sel;
    logic         accept;

    assign accept = (state == IDLE) && start;

    // The single expansion round, fed back from the working register.
    key_exp u_key_exp (
        .key_exp_in   (work),
        .round_number (round_cnt),
        .key_exp_out  (kexp_out)
    );

    // Sequencer: accept a key in IDLE, then step rounds 1..NR in EXPAND.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            round_cnt  <= 4'd0;
            work       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work       <= key_in;
                        round_cnt  <= 4'd1;
                        busy       <= 1'b1;
                        keys_valid <= 1'b0;
                        state      <= EXPAND;
                    end
                end
                EXPAND: begin
                    work <= kexp_out;
                    if (round_cnt == LAST_ROUND) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        round_cnt  <= 4'd0;
                        done       <= 1'b1;
                        keys_valid <= 1'b1;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Round-key register file: slot 0 takes the cipher key on accept,
    // slot n takes the expansion output while round n is being computed.
    genvar gi;
    generate
        for (gi = 0; gi < NSLOTS; gi++) begin : g_slot
            logic         we;
            logic [0:127] wdata;
            logic [0:127] q;

            if (gi == 0) begin : g_key
                assign we    = accept;
                assign wdata = key_in;
            end else begin : g_round
                assign we    = (state == EXPAND) && (round_cnt == 4'(gi));
                assign wdata = kexp_out;
            end

            // Hold the round key until this slot's round comes around again.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q <= '0;
                end else if (we) begin
                    q <= wdata;
                end
            end

            assign slot_q[gi] = q;
        end
    endgenerate

    // Read select; indices past the last slot read as zero.
    always_comb begin
        rd_sel = '0;
        if (rd_idx <= LAST_SLOT) begin
            rd_sel = slot_q[rd_idx];
        end
    end

    generate
        if (RD_LATENCY == 0) begin : g_rd_comb
            assign rd_key = rd_sel;
        end else begin : g_rd_reg
            // Registered read: the key for rd_idx appears one cycle later.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_key <= '0;
                end else begin
                    rd_key <= rd_sel;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl (registered read port).
// The reference builds the S-box from GF(2^8) arithmetic and expands keys
// word by word, independently of the RTL structure.
module tb_key_schedule_ctrl;

    logic         clk;
    logic         rst;
    logic [0:127] key_in;
    logic         start;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [3:0]   rd_idx;
    logic [0:127] rd_key;

    int checks;
    int errors;

    logic [7:0]   sbox_tab    [0:255];
    logic [127:0] exp_keys    [0:10];
    logic [127:0] model_slots [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    key_schedule_ctrl #(.NR(10), .RD_LATENCY(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        logic       hi;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox_tab[a] = s;
        end
    endtask

    // FIPS-197 key expansion over 44 words, round keys grouped by four.
    task automatic compute_expansion(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]], sbox_tab[t[31:24]]}
                     ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic read_check(input int idx, input string tag);
        logic [127:0] exp;
        rd_idx = 4'(idx);
        tick();
        exp = (idx <= 10) ? model_slots[idx] : 128'h0;
        check(tag, rd_key, exp);
        $display("READ idx=%0d key=%h", idx, rd_key);
    endtask

    // One full expansion; noise injects ignored start pulses at cycles 3 and 7.
    task automatic run_exp(input logic [127:0] key, input bit noise);
        int busy_cycles;
        int early_done;
        key_in = key;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("e0_busy", 128'(busy), 128'(1'b1));
        check("e0_kv_drop", 128'(keys_valid), 128'(1'b0));
        busy_cycles = busy ? 1 : 0;
        early_done  = 0;
        for (int c = 1; c < 40 && busy; c++) begin
            if (noise) begin
                key_in = rand_key();
                start  = (c == 3 || c == 7);
            end else begin
                start = 1'b0;
            end
            if (done) early_done++;
            tick();
            if (busy) busy_cycles++;
        end
        start = 1'b0;
        check("busy_cycles", 128'(busy_cycles), 128'(10));
        check("done_while_busy", 128'(early_done), 128'(0));
        check("done_pulse", 128'(done), 128'(1'b1));
        check("kv_set", 128'(keys_valid), 128'(1'b1));
        compute_expansion(key);
        for (int r = 0; r < 11; r++) model_slots[r] = exp_keys[r];
        tick();
        check("done_clear", 128'(done), 128'(1'b0));
        $display("EXPAND key=%h busy_cycles=%0d", key, busy_cycles);
    endtask

    initial begin
        int d1;
        int d2;
        int ndone;
        logic [127:0] k;

        checks = 0;
        errors = 0;
        clk    = 1'b0;
        rst    = 1'b0;
        start  = 1'b0;
        key_in = '0;
        rd_idx = 4'd0;
        build_sbox();
        for (int r = 0; r < 11; r++) model_slots[r] = 128'h0;

        // Test 1: asynchronous reset takes effect without a clock edge.
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_done", 128'(done), 128'(1'b0));
        check("rst_kv", 128'(keys_valid), 128'(1'b0));
        check("rst_rdkey", rd_key, 128'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i <= 10; i++) read_check(i, "rst_slot");

        // Test 2: FIPS-197 vector, with fixed reference values.
        run_exp(FIPS_KEY, 1'b0);
        read_check(0, "fips_slot0");
        check("fips_k0", rd_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        rd_idx = 4'd1;
        #1;
        check("rd_latency_hold", rd_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        read_check(1, "fips_slot1");
        check("fips_k1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
        read_check(10, "fips_slot10");
        check("fips_k10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Test 3: start pulses during expansion are ignored.
        run_exp(FIPS_KEY, 1'b1);
        for (int i = 0; i <= 10; i++) read_check(i, "noise_slot");

        // Test 4: all-zero key replaces the previous set.
        run_exp(128'h0, 1'b0);
        read_check(1, "zero_slot1");
        check("zero_k1", rd_key, 128'h62636363626363636263636362636363);
        read_check(10, "zero_slot10");
        check("zero_k10", rd_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Test 5: reset in the middle of round 5.
        key_in = FIPS_KEY;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 128'(busy), 128'(1'b0));
        check("midrst_kv", 128'(keys_valid), 128'(1'b0));
        check("midrst_rdkey", rd_key, 128'h0);
        tick();
        rst = 1'b0;
        for (int r = 0; r < 11; r++) model_slots[r] = 128'h0;
        ndone = 0;
        rd_idx = 4'd1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done || busy) ndone++;
        end
        check("midrst_no_done", 128'(ndone), 128'(0));
        check("midrst_slot1", rd_key, 128'h0);
        run_exp(FIPS_KEY, 1'b0);
        read_check(10, "after_rst_slot10");

        // Test 6: out-of-range reads and start held high for 25 cycles.
        k      = rand_key();
        key_in = k;
        start  = 1'b1;
        d1     = 0;
        d2     = 0;
        ndone  = 0;
        for (int c = 1; c <= 25; c++) begin
            rd_idx = 4'(11 + $urandom_range(0, 4));
            tick();
            check("oob_read", rd_key, 128'h0);
            if (done) begin
                ndone++;
                if (d1 == 0) d1 = c;
                else if (d2 == 0) d2 = c;
            end
        end
        start = 1'b0;
        check("held_done1", 128'(d1), 128'(11));
        check("held_done2", 128'(d2), 128'(22));
        check("held_ndone", 128'(ndone), 128'(2));
        $display("HELD done_at=%0d,%0d", d1, d2);
        for (int c = 0; c < 20 && busy; c++) tick();
        check("held_final_idle", 128'(busy), 128'(1'b0));
        compute_expansion(k);
        for (int r = 0; r < 11; r++) model_slots[r] = exp_keys[r];
        tick();
        for (int i = 0; i <= 10; i++) read_check(i, "held_slot");

        // Randomized keys and reads against the reference expansion.
        for (int t = 0; t < 4; t++) begin
            run_exp(rand_key(), 1'b0);
            for (int j = 0; j < 6; j++) read_check(int'($urandom_range(0, 15)), "rand_read");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_schedule_ctrl.md
Name: key_schedule_ctrl

Overview:
Iterative AES-128 key-schedule sequencer. It sits directly upstream of the key_exp stage and also consumes its output. It loads the 128-bit cipher key and drives key_exp for one round per clock, rounds 1..10, feeding each result back as the next input. All 11 round keys are held in an internal register file. The cipher datapath reads round keys from that file by index.

Parameters:
NR, 10, number of expansion rounds; only 10 (AES-128) is supported.
RD_LATENCY, 1, read-port latency in cycles; legal values are 0 (combinational read) or 1 (registered read).

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
key_in  input  [0:127]  cipher key; bit 0 is the MSB of byte 0; sampled when start is accepted.
start  input  1  request expansion of key_in.
busy  output  1  high while expansion is in progress.
done  output  1  one-cycle pulse after round key 10 is written.
keys_valid  output  1  high when all 11 slots hold the keys of the most recent key_in.
rd_idx  input  4  round-key index to read, 0..10.
rd_key  output  [0:127]  round key stored at rd_idx.

Behaviour:
- Reset (async, any state): FSM to IDLE; round counter = 0; working register = 0; all 11 slots = 0. busy, done, keys_valid and rd_key all = 0.
- FSM states: IDLE and EXPAND.
- IDLE, start=1, accepted at edge E0:
  - slot0 <= key_in; working reg <= key_in; round_cnt <= 1.
  - busy <= 1; keys_valid <= 0.
  - State goes to EXPAND.
- EXPAND: one key_exp instance is driven by key_exp_in = working reg and round_number = round_cnt. At each edge En (n = 1..10):
  - slot[n] <= key_exp_out; working reg <= key_exp_out; round_cnt <= round_cnt + 1.
- Completion, at E10 (round_cnt = 10):
  - State goes to IDLE; busy <= 0; round_cnt <= 0.
  - done <= 1 for exactly one cycle; keys_valid <= 1.
- Latency: busy is high for exactly 10 cycles. done and keys_valid are first seen high in the cycle after E10.
- start while busy: ignored. No restart, no queuing, and key_in is not sampled.
- start in IDLE with keys_valid=1: accepted as a new expansion. keys_valid drops at E0. Old slots are overwritten progressively.
- start held high continuously: a new expansion begins on the first IDLE cycle, which is the edge after E10. done still pulses in that cycle.
- round_cnt never exceeds 10; values 0 and 11..15 are never presented to key_exp while in EXPAND.
- Read port, RD_LATENCY=1: rd_key <= slot[rd_idx] on every edge.
- Read port, RD_LATENCY=0: rd_key is a combinational slot[rd_idx].
- Read port, rd_idx > 10: rd_key = 0.
- Read port during EXPAND: returns current slot contents, which may be stale. Consumers must gate reads on keys_valid.
- Reset asserted mid-EXPAND: everything clears immediately, keys_valid = 0, and no done pulse is generated.
- All words and bytes keep big-endian ordering: word w0 is bits [0:31] and byte k0 is bits [0:7].

Test Plan:
1. Reset values: assert rst mid-cycle, no clock edge -> busy=0, done=0, keys_valid=0, rd_key=0 immediately. After release, rd_idx=0..10 all read 0.
2. FIPS-197 vector: key_in=2b7e151628aed2a6abf7158809cf4f3c, 1-cycle start pulse -> busy high for 10 cycles, then done for 1 cycle and keys_valid=1. Reads must return:
   - rd_idx=0 -> 2b7e151628aed2a6abf7158809cf4f3c
   - rd_idx=1 -> a0fafe1788542cb123a339392a6c7605
   - rd_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6
   - each read appears one cycle after rd_idx is applied.
3. start pulsed again at cycles 3 and 7 of the expansion with a different key_in -> ignored. Completion timing is unchanged and the slots match test 2.
4. After test 2, start with key_in=000...0 -> keys_valid drops at E0. After completion:
   - rd_idx=1 -> 62636363626363636263636362636363
   - rd_idx=10 -> b4ef5bcb3e92e21123e951cf6f8f188e
5. rst asserted at round 5 -> immediate clear, no done pulse. Then a fresh start with the test-2 key -> correct keys after exactly 10 cycles.
6. rd_idx=11..15 at any time -> rd_key=0. Also, start held high for 25 cycles -> done pulses at cycles 11 and 22, with one idle-accept cycle between expansions.
